// File: rtl/calc_pkg.sv
// ------------------------------------------------------------------
// calc_pkg: shared widths, readout state enum and BCD helper. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package calc_pkg;

   localparam int RESULT_W   = 25;
   localparam int MAG_W      = 25;
   localparam int NUM_DIGITS = 8;
   localparam int BCD_W      = 4 * NUM_DIGITS;
   localparam int CNT_W      = 5;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } rr_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] adj;
      adj = acc;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
         end
      end
      return adj;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg7.sv
// ------------------------------------------------------------------
// bcd_to_seg7: BCD digit to active-low {g,f,e,d,c,b,a}; RESULT_SCAN_EN only. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

`ifdef RESULT_SCAN_EN
module bcd_to_seg7
   import calc_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule
`endif

`default_nettype wire

// File: rtl/result_readout.sv
// ------------------------------------------------------------------
// result_readout: captures the 25-bit result, converts |result| to 8 BCD digits.
// Optional 8-digit scanned display under RESULT_SCAN_EN. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module result_readout
   import calc_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_r,
   input  logic [RESULT_W-1:0] result,
   output logic [BCD_W-1:0]    bcd,
   output logic                neg,
   output logic                busy,
   output logic                valid
`ifdef RESULT_SCAN_EN
   ,
   output logic [7:0]          anode,
   output logic [6:0]          seg
`endif
);

   if (SCAN_DIV < 2) begin : g_bad_scan_div
      $error("result_readout: SCAN_DIV must be at least 2");
   end

   rr_state_t         state;
   logic [MAG_W-1:0]  mag;
   logic [BCD_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              neg_pend;

   logic [MAG_W-1:0]  w_abs;
   logic [BCD_W-1:0]  w_acc_adj;
   logic [BCD_W-1:0]  w_acc_next;
   logic [MAG_W-1:0]  w_mag_next;

   // 25-bit magnitude so that -2^24 maps cleanly to 2^24.
   assign w_abs      = result[RESULT_W-1] ? (~result + 1'b1) : result;
   assign w_acc_adj  = add3_digits(acc);
   assign w_acc_next = {w_acc_adj[BCD_W-2:0], mag[MAG_W-1]};
   assign w_mag_next = {mag[MAG_W-2:0], 1'b0};

   // bcd/neg only move on completion; neg_pend carries the captured sign until then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mag      <= '0;
         acc      <= '0;
         cnt      <= '0;
         neg_pend <= 1'b0;
         bcd      <= '0;
         neg      <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
      end else if (ld_r) begin
         state    <= CONV;
         mag      <= w_abs;
         acc      <= '0;
         cnt      <= '0;
         neg_pend <= result[RESULT_W-1];
         busy     <= 1'b1;
         valid    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= IDLE;
            end
            CONV: begin
               acc <= w_acc_next;
               mag <= w_mag_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(MAG_W - 1)) begin
                  bcd   <= w_acc_next;
                  neg   <= neg_pend;
                  valid <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RESULT_SCAN_EN
   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic [3:0]       w_digit;
   logic [BCD_W-1:0] w_upper;
   logic             w_blank;
   logic [6:0]       w_seg;

   assign w_digit = bcd[{idx, 2'b00} +: 4];
   assign w_upper = bcd >> {idx, 2'b00};
   // Leading zeros blank; the ones digit always shows.
   assign w_blank = (idx != 3'd0) && (w_upper == '0);

   bcd_to_seg7 u_seg7 (
      .digit (w_digit),
      .blank (w_blank),
      .seg   (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= '0;
         anode   <= 8'hFF;
         seg     <= SEG_BLANK;
      end else begin
         if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            idx     <= idx + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         anode <= ~(8'b1 << idx);
         seg   <= w_seg;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_result_readout.sv
// ------------------------------------------------------------------
// tb_result_readout: vector table, hand sequences and random model check. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_result_readout;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_r = 1'b0;
   logic [24:0] result = '0;
   logic [31:0] bcd;
   logic        neg;
   logic        busy;
   logic        valid;
`ifdef RESULT_SCAN_EN
   logic [7:0]  anode;
   logic [6:0]  seg;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   result_readout #(.SCAN_DIV(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ld_r   (ld_r),
      .result (result),
      .bcd    (bcd),
      .neg    (neg),
      .busy   (busy),
      .valid  (valid)
`ifdef RESULT_SCAN_EN
      ,
      .anode  (anode),
      .seg    (seg)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [24:0] res;
      logic [31:0] exp_bcd;
      logic        exp_neg;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference conversion: plain decimal arithmetic on the signed value.
   function automatic logic [31:0] to_bcd(input logic [24:0] r);
      int m;
      logic [31:0] b;
      m = r[24] ? (33554432 - int'(r)) : int'(r);
      b = '0;
      for (int i = 0; i < 8; i++) begin
         b[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return b;
   endfunction

   function automatic logic [35:0] pack(input logic b, input logic v, input logic n, input logic [31:0] d);
      return {b, v, 1'b0, n, d};
   endfunction

   task automatic run_conv(input logic [24:0] r, input logic [31:0] eb, input logic en,
                           input logic [31:0] ob, input logic on);
      ld_r   = 1'b1;
      result = r;
      tick();
      ld_r   = 1'b0;
      result = 25'($urandom);
      check("conv_start", pack(busy, valid, neg, bcd), pack(1'b1, 1'b0, on, ob));
      for (int i = 1; i < 25; i++) begin
         tick();
         check("conv_busy", pack(busy, valid, neg, bcd), pack(1'b1, 1'b0, on, ob));
      end
      tick();
      check("conv_done", pack(busy, valid, neg, bcd), pack(1'b0, 1'b1, en, eb));
   endtask

   logic [31:0] old_b;
   logic        old_n;
   logic [24:0] pend;
   logic [31:0] m_b;
   logic        m_n, m_busy, m_valid;
   int          remain;

   initial begin
      vecs[0] = '{25'd12345,    32'h00012345, 1'b0};
      vecs[1] = '{25'h1FFFFFF,  32'h00000001, 1'b1};
      vecs[2] = '{25'h1000000,  32'h16777216, 1'b1};
      vecs[3] = '{25'd0,        32'h00000000, 1'b0};
      vecs[4] = '{25'h0FFFFFF,  32'h16777215, 1'b0};
      vecs[5] = '{-25'sd12345,  32'h00012345, 1'b1};
      vecs[6] = '{25'd9,        32'h00000009, 1'b0};
      vecs[7] = '{25'd10000000, 32'h10000000, 1'b0};

      #12;
      check("reset_async", pack(busy, valid, neg, bcd), '0);
`ifdef RESULT_SCAN_EN
      check("reset_scan", {21'd0, anode, seg}, {21'd0, 8'hFF, 7'h7F});
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_after_reset", pack(busy, valid, neg, bcd), '0);

      old_b = '0;
      old_n = 1'b0;
      for (int v = 0; v < 8; v++) begin
         run_conv(vecs[v].res, vecs[v].exp_bcd, vecs[v].exp_neg, old_b, old_n);
         old_b = vecs[v].exp_bcd;
         old_n = vecs[v].exp_neg;
      end

      // Restart: 5555 aborted at N+10 by 999, which completes at N+35.
      ld_r = 1'b1; result = 25'd5555;
      tick();
      ld_r = 1'b0;
      for (int i = 1; i < 10; i++) begin
         tick();
         check("restart_pre", pack(busy, valid, neg, bcd), pack(1'b1, 1'b0, old_n, old_b));
      end
      ld_r = 1'b1; result = 25'd999;
      tick();
      ld_r = 1'b0;
      check("restart_load", pack(busy, valid, neg, bcd), pack(1'b1, 1'b0, old_n, old_b));
      for (int i = 11; i < 35; i++) begin
         tick();
         check("restart_hold", pack(busy, valid, neg, bcd), pack(1'b1, 1'b0, old_n, old_b));
      end
      tick();
      check("restart_done", pack(busy, valid, neg, bcd), pack(1'b0, 1'b1, 1'b0, 32'h00000999));

      // Reset in the middle of a conversion.
      ld_r = 1'b1; result = 25'd777;
      tick();
      ld_r = 1'b0;
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_conv", pack(busy, valid, neg, bcd), '0);
`ifdef RESULT_SCAN_EN
      check("reset_mid_scan", {21'd0, anode, seg}, {21'd0, 8'hFF, 7'h7F});
`endif
      #1 rst_n = 1'b1;
      tick();
      check("idle_after_reset2", pack(busy, valid, neg, bcd), '0);

`ifdef RESULT_SCAN_EN
      run_conv(25'd42, 32'h00000042, 1'b0, 32'h0, 1'b0);
      begin
         logic [7:0] prev;
         int guard;
         logic [6:0] exp_seg;
         prev  = anode;
         guard = 0;
         tick();
         while (!(anode == 8'hFE && prev != 8'hFE) && guard < 64) begin
            prev = anode;
            tick();
            guard++;
         end
         check("scan_sync", {28'd0, anode}, {28'd0, 8'hFE});
         for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick();
            exp_seg = ((k / 4) % 8 == 0) ? 7'h24 : ((k / 4) % 8 == 1) ? 7'h19 : 7'h7F;
            check("scan_step", {21'd0, anode, seg},
                  {21'd0, ~(8'b1 << ((k / 4) % 8)), exp_seg});
         end
      end
`endif

      // Random traffic against a cycle-level behavioural model.
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      m_b = '0; m_n = 1'b0; m_busy = 1'b0; m_valid = 1'b0; remain = 0; pend = '0;
      for (int c = 0; c < 3000; c++) begin
         logic        ld;
         logic [24:0] r;
         int          pick;
         ld   = ($urandom_range(0, 29) == 0);
         pick = $urandom_range(0, 9);
         r    = (pick == 0) ? 25'h1000000 : (pick == 1) ? 25'h0FFFFFF : 25'($urandom);
         tick();
         ld_r = ld; result = r;
         tick();
         ld_r = 1'b0;
         if (ld) begin
            pend = r; remain = 25; m_busy = 1'b1; m_valid = 1'b0;
         end else if (remain > 0) begin
            remain--;
            if (remain == 0) begin
               m_b = to_bcd(pend); m_n = pend[24]; m_valid = 1'b1; m_busy = 1'b0;
            end
         end
         check("random", pack(busy, valid, neg, bcd), pack(m_busy, m_valid, m_n, m_b));
         // the idle tick at the loop head is a non-load cycle for the model
         if (remain > 0) begin
            remain--;
            if (remain == 0) begin
               m_b = to_bcd(pend); m_n = pend[24]; m_valid = 1'b1; m_busy = 1'b0;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
